// File: rtl/processor.sv
// Single-cycle MIPS32 subset: instruction ROM, control decoder, datapath with
// register file and HI/LO, and a word-addressed data RAM behind one clock.

package processor_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_t;

    typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_HI, WB_LO} wb_t;

    typedef struct packed {
        logic    regwrite;
        dst_t    dst;
        wb_t     wb;
        logic    alusrc;
        logic    zeroext;
        alu_op_t aluop;
        logic    memwrite;
        logic    beq;
        logic    bne;
        logic    jump;
        logic    jr;
        logic    multu;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                           F_JR   = 6'h08, F_MFHI = 6'h10, F_MFLO = 6'h12,
                           F_MULTU = 6'h19, F_ADD = 6'h20, F_ADDU = 6'h21,
                           F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24,
                           F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27,
                           F_SLT  = 6'h2a, F_SLTU = 6'h2b;
endpackage

module instr_rom #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        load_en,
    input  logic [29:0] load_addr,
    input  logic [31:0] load_data,
    input  logic [29:0] addr,
    output logic [31:0] instr
);
    logic [31:0] INSTRROM [0:WORDS-1];

    // Contents are also preloaded hierarchically, so this is a plain always rather
    // than an exclusive-writer always_ff.
    always @(posedge clk) begin
        if (load_en)
            INSTRROM[load_addr % 30'(WORDS)] <= load_data;
    end

    assign instr = INSTRROM[addr % 30'(WORDS)];
endmodule

module data_ram #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] RAM [0:WORDS-1];

    // NOTE: storage arrays carry no reset; only control state (PC, HI/LO) is reset.
    always @(posedge clk) begin
        if (we)
            RAM[addr % 30'(WORDS)] <= wdata;
    end

    assign rdata = RAM[addr % 30'(WORDS)];
endmodule

module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always @(posedge clk) begin
        if (reset && we && wa != 5'd0)
            registers[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module controller
    import processor_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        // NOTE: the whole struct is defaulted first so no path can infer a latch.
        ctrl       = '0;
        ctrl.dst   = DST_RT;
        ctrl.wb    = WB_ALU;
        ctrl.aluop = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                ctrl.dst      = DST_RD;
                ctrl.regwrite = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: ctrl.aluop = ALU_ADD;
                    F_SUB, F_SUBU: ctrl.aluop = ALU_SUB;
                    F_AND:   ctrl.aluop = ALU_AND;
                    F_OR:    ctrl.aluop = ALU_OR;
                    F_XOR:   ctrl.aluop = ALU_XOR;
                    F_NOR:   ctrl.aluop = ALU_NOR;
                    F_SLT:   ctrl.aluop = ALU_SLT;
                    F_SLTU:  ctrl.aluop = ALU_SLTU;
                    F_SLL:   ctrl.aluop = ALU_SLL;
                    F_SRL:   ctrl.aluop = ALU_SRL;
                    F_SRA:   ctrl.aluop = ALU_SRA;
                    F_MFHI:  ctrl.wb    = WB_HI;
                    F_MFLO:  ctrl.wb    = WB_LO;
                    F_JR: begin
                        ctrl.regwrite = 1'b0;
                        ctrl.jr       = 1'b1;
                    end
                    F_MULTU: begin
                        ctrl.regwrite = 1'b0;
                        ctrl.multu    = 1'b1;
                    end
                    default: ctrl.regwrite = 1'b0;
                endcase
            end
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.dst      = DST_RA;
                ctrl.wb       = WB_PC4;
            end
            OP_BEQ: ctrl.beq = 1'b1;
            OP_BNE: ctrl.bne = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                case (op)
                    OP_SLTI:  ctrl.aluop = ALU_SLT;
                    OP_SLTIU: ctrl.aluop = ALU_SLTU;
                    OP_ANDI:  begin ctrl.aluop = ALU_AND; ctrl.zeroext = 1'b1; end
                    OP_ORI:   begin ctrl.aluop = ALU_OR;  ctrl.zeroext = 1'b1; end
                    OP_XORI:  begin ctrl.aluop = ALU_XOR; ctrl.zeroext = 1'b1; end
                    OP_LUI:   ctrl.aluop = ALU_LUI;
                    default:  ctrl.aluop = ALU_ADD;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.wb       = WB_MEM;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module datapath
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ctrl_t       ctrl,
    input  logic [25:0] instr,
    input  logic [31:0] readdata,
    output logic [29:0] fetch_addr,
    output logic [29:0] mem_addr,
    output logic [31:0] writedata,
    output logic        memwrite
);
    logic [31:0] pc, pc4, pc_next, hi, lo;
    logic [31:0] rsv, rtv, immx, srcb, alur, wbv;
    logic [4:0]  wa;
    logic        taken;

    wire [4:0] rs    = instr[25:21];
    wire [4:0] rt    = instr[20:16];
    wire [4:0] rd    = instr[15:11];
    wire [4:0] shamt = instr[10:6];

    regfile gpr (
        .clk(clk), .reset(reset), .we(ctrl.regwrite),
        .ra1(rs), .ra2(rt), .wa(wa), .wd(wbv), .rd1(rsv), .rd2(rtv)
    );

    assign pc4  = pc + 32'd4;
    assign immx = ctrl.zeroext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign srcb = ctrl.alusrc ? immx : rtv;

    always_comb begin
        alur = '0;
        case (ctrl.aluop)
            ALU_ADD:  alur = rsv + srcb;
            ALU_SUB:  alur = rsv - srcb;
            ALU_AND:  alur = rsv & srcb;
            ALU_OR:   alur = rsv | srcb;
            ALU_XOR:  alur = rsv ^ srcb;
            ALU_NOR:  alur = ~(rsv | srcb);
            ALU_SLT:  alur = {31'd0, $signed(rsv) < $signed(srcb)};
            ALU_SLTU: alur = {31'd0, rsv < srcb};
            ALU_SLL:  alur = rtv << shamt;
            ALU_SRL:  alur = rtv >> shamt;
            ALU_SRA:  alur = $unsigned($signed(rtv) >>> shamt);
            ALU_LUI:  alur = {instr[15:0], 16'h0};
            default:  alur = '0;
        endcase
    end

    always_comb begin
        wbv = alur;
        case (ctrl.wb)
            WB_MEM:  wbv = readdata;
            WB_PC4:  wbv = pc4;
            WB_HI:   wbv = hi;
            WB_LO:   wbv = lo;
            default: wbv = alur;
        endcase
    end

    always_comb begin
        wa = rt;
        case (ctrl.dst)
            DST_RD:  wa = rd;
            DST_RA:  wa = 5'd31;
            default: wa = rt;
        endcase
    end

    assign taken = (ctrl.beq && rsv == rtv) || (ctrl.bne && rsv != rtv);

    always_comb begin
        pc_next = pc4;
        if (ctrl.jr)
            pc_next = rsv;
        else if (ctrl.jump)
            pc_next = {pc4[31:28], instr[25:0], 2'b00};
        else if (taken)
            pc_next = pc4 + {immx[29:0], 2'b00};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the single-cycle retire semantics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            pc <= pc_next;
            if (ctrl.multu)
                {hi, lo} <= 64'(rsv) * 64'(rtv);
        end
    end

    assign fetch_addr = pc[31:2];
    assign mem_addr   = alur[31:2];
    assign writedata  = rtv;
    assign memwrite   = ctrl.memwrite & reset;
endmodule

module mips
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] readdata,
    output logic [29:0] fetch_addr,
    output logic [29:0] mem_addr,
    output logic [31:0] writedata,
    output logic        memwrite
);
    ctrl_t ctrl;

    controller ctl (.op(instr[31:26]), .funct(instr[5:0]), .ctrl(ctrl));

    datapath dp (
        .clk(clk), .reset(reset), .ctrl(ctrl), .instr(instr[25:0]),
        .readdata(readdata), .fetch_addr(fetch_addr), .mem_addr(mem_addr),
        .writedata(writedata), .memwrite(memwrite)
    );
endmodule

module processor #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input logic clk,
    input logic reset
);
    logic [29:0] fetch_addr, mem_addr;
    logic [31:0] instr, writedata, readdata;
    logic        memwrite;

    // The ROM load port is left idle; program images are placed hierarchically.
    instr_rom #(.WORDS(IMEM_WORDS)) imem (
        .clk(clk), .load_en(1'b0), .load_addr(30'd0), .load_data(32'd0),
        .addr(fetch_addr), .instr(instr)
    );

    mips mips (
        .clk(clk), .reset(reset), .instr(instr), .readdata(readdata),
        .fetch_addr(fetch_addr), .mem_addr(mem_addr),
        .writedata(writedata), .memwrite(memwrite)
    );

    data_ram #(.WORDS(DMEM_WORDS)) dmem (
        .clk(clk), .we(memwrite), .addr(mem_addr),
        .wdata(writedata), .rdata(readdata)
    );
endmodule

// File: tb/tb_processor.sv
// Bench for processor: directed programs plus a random instruction stream, all
// checked against an instruction-level interpreter of the MIPS subset.

module tb_processor;
    localparam int IMEM = 64;
    localparam int DMEM = 64;

    localparam logic [5:0] RFN [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                                        6'h03, 6'h08, 6'h10, 6'h12, 6'h19};
    localparam logic [5:0] IOP [15] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                                        6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05,
                                        6'h02, 6'h03, 6'h3f};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_dm  [DMEM];
    logic [31:0] m_rom [IMEM];
    logic [31:0] m_pc, m_hi, m_lo;

    processor #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM)) dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int target);
        return {6'(op), 26'(target)};
    endfunction

    function automatic logic [31:0] rv(logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : m_reg[r];
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // Instruction-level interpreter: one call retires one instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, pc4, npc, ea;
        logic [4:0]  rs, rt, rd, sh;
        ins = m_rom[(m_pc >> 2) % 32'(IMEM)];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        a = rv(rs); b = rv(rt);
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        ea = a + se;
        pc4 = m_pc + 32'd4;
        npc = pc4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: wr(rd, a + b);
                6'h22, 6'h23: wr(rd, a - b);
                6'h24: wr(rd, a & b);
                6'h25: wr(rd, a | b);
                6'h26: wr(rd, a ^ b);
                6'h27: wr(rd, ~(a | b));
                6'h2a: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h2b: wr(rd, (a < b) ? 32'd1 : 32'd0);
                6'h00: wr(rd, b << sh);
                6'h02: wr(rd, b >> sh);
                6'h03: wr(rd, $unsigned($signed(b) >>> sh));
                6'h08: npc = a;
                6'h10: wr(rd, m_hi);
                6'h12: wr(rd, m_lo);
                6'h19: {m_hi, m_lo} = 64'(a) * 64'(b);
                default: ;
            endcase
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wr(5'd31, pc4); end
            6'h04: if (a == b) npc = pc4 + (se << 2);
            6'h05: if (a != b) npc = pc4 + (se << 2);
            6'h08, 6'h09: wr(rt, a + se);
            6'h0a: wr(rt, ($signed(a) < $signed(se)) ? 32'd1 : 32'd0);
            6'h0b: wr(rt, (a < se) ? 32'd1 : 32'd0);
            6'h0c: wr(rt, a & ze);
            6'h0d: wr(rt, a | ze);
            6'h0e: wr(rt, a ^ ze);
            6'h0f: wr(rt, {ins[15:0], 16'h0});
            6'h23: wr(rt, m_dm[(ea >> 2) % 32'(DMEM)]);
            6'h2b: m_dm[(ea >> 2) % 32'(DMEM)] = b;
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s r%0d", tag, i), (i == 0) ? 32'd0 : dut.mips.dp.gpr.registers[i],
                  (i == 0) ? 32'd0 : m_reg[i]);
        check({tag, " r0 read"}, dut.mips.dp.rsv, rv(dut.mips.dp.rs));
        check({tag, " hi"}, dut.mips.dp.hi, m_hi);
        check({tag, " lo"}, dut.mips.dp.lo, m_lo);
    endtask

    // Holds reset, preloads ROM, registers and RAM, checks reset state, releases.
    task automatic load_program(input logic [31:0] prog [$], input logic [31:0] fill, input bit rand_fill);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < IMEM; i++) begin
            m_rom[i] = (i < prog.size()) ? prog[i] : 32'd0;
            dut.imem.INSTRROM[i] = m_rom[i];
        end
        for (int i = 1; i < 32; i++) begin
            m_reg[i] = rand_fill ? $urandom : fill;
            dut.mips.dp.gpr.registers[i] = m_reg[i];
        end
        for (int i = 0; i < DMEM; i++) begin
            m_dm[i] = rand_fill ? $urandom : 32'd0;
            dut.dmem.RAM[i] = m_dm[i];
        end
        m_reg[0] = 32'd0;
        m_pc = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk);
        #1;
        check("reset pc", dut.mips.dp.pc, 32'd0);
        check_state("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check("pc", dut.mips.dp.pc, m_pc);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 31);
        if (k < 17)
            return enc_r(int'(RFN[k]), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 31));
        else if (k < 31)
            return enc_i(int'(IOP[k - 17]), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 65535)) | ((k >= 29) ? 32'd0 : 32'd0);
        else
            return enc_r(6'h3f, $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(1, 31), 0);
    endfunction

    logic [31:0] p1 [$], fib [$], pj [$], pm [$], ps [$], pr [$];

    initial begin
        p1  = '{enc_i(6'h0f, 0, 1, 16'h1234), enc_i(6'h0d, 1, 1, 16'h5678), enc_i(6'h09, 0, 2, -1)};
        fib = '{enc_i(6'h08, 0, 1, 0), enc_i(6'h08, 0, 2, 1), enc_r(6'h20, 1, 2, 3, 0),
                enc_r(6'h20, 2, 0, 1, 0), enc_r(6'h20, 3, 0, 2, 0), enc_j(6'h02, 2)};
        pj  = '{enc_j(6'h03, 3), enc_i(6'h08, 0, 5, 9), enc_j(6'h02, 2),
                enc_i(6'h08, 0, 4, 7), enc_r(6'h08, 31, 0, 0, 0)};
        pm  = '{enc_i(6'h08, 0, 5, 6), enc_i(6'h08, 0, 6, 7), enc_r(6'h19, 5, 6, 0, 0),
                enc_r(6'h12, 0, 0, 7, 0), enc_r(6'h10, 0, 0, 8, 0)};
        ps  = '{enc_i(6'h2b, 0, 1, 4), enc_i(6'h23, 0, 9, 4), enc_i(6'h04, 0, 0, 1),
                enc_i(6'h08, 0, 10, 1), enc_i(6'h08, 0, 11, 2), enc_i(6'h08, 0, 0, 5)};
        for (int i = 0; i < IMEM; i++) pr.push_back(rand_instr());

        // Asynchronous reset: PC clears between clock edges.
        #12 reset = 1'b0;
        #1 check("async pc", dut.mips.dp.pc, 32'd0);

        load_program(p1, 32'hcafebabe, 1'b0);
        run(3);
        check("lui/ori r1", dut.mips.dp.gpr.registers[1], 32'h12345678);
        check("addiu r2", dut.mips.dp.gpr.registers[2], 32'hffffffff);
        check("untouched r3", dut.mips.dp.gpr.registers[3], 32'hcafebabe);
        check_state("p1");

        // 2 setup instructions then 27 loop instructions: 7 updates of (a,b).
        load_program(fib, 32'hcafebabe, 1'b0);
        run(29);
        check("fib r1", dut.mips.dp.gpr.registers[1], 32'd13);
        check("fib r2", dut.mips.dp.gpr.registers[2], 32'd21);
        check("fib r3", dut.mips.dp.gpr.registers[3], 32'd21);
        check_state("fib");

        load_program(pj, 32'hcafebabe, 1'b0);
        run(5);
        check("jal r31", dut.mips.dp.gpr.registers[31], 32'd4);
        check("sub r4", dut.mips.dp.gpr.registers[4], 32'd7);
        check("resume r5", dut.mips.dp.gpr.registers[5], 32'd9);
        check("spin pc", dut.mips.dp.pc, 32'd8);
        check_state("jal");

        load_program(pm, 32'hcafebabe, 1'b0);
        run(5);
        check("mflo r7", dut.mips.dp.gpr.registers[7], 32'd42);
        check("mfhi r8", dut.mips.dp.gpr.registers[8], 32'd0);
        check_state("multu");

        load_program(ps, 32'hcafebabe, 1'b0);
        run(5);
        check("lw r9", dut.mips.dp.gpr.registers[9], 32'hcafebabe);
        check("skipped r10", dut.mips.dp.gpr.registers[10], 32'hcafebabe);
        check("after beq r11", dut.mips.dp.gpr.registers[11], 32'd2);
        check("sw ram", dut.dmem.RAM[1], 32'hcafebabe);
        check_state("mem");

        // Reset mid-program: the in-flight instruction is dropped, nothing writes.
        load_program(fib, 32'h0, 1'b0);
        run(10);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        #1 check("mid reset pc", dut.mips.dp.pc, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1 check("held pc", dut.mips.dp.pc, 32'd0);
        end
        check_state("during reset");
        @(negedge clk);
        reset = 1'b1;
        run(29);
        check("rerun r1", dut.mips.dp.gpr.registers[1], 32'd13);
        check("rerun r2", dut.mips.dp.gpr.registers[2], 32'd21);
        check_state("rerun");

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < IMEM; i++) pr[i] = rand_instr();
            load_program(pr, 32'h0, 1'b1);
            run(300);
            check_state($sformatf("rand%0d", t));
            for (int i = 0; i < DMEM; i++)
                check($sformatf("rand%0d ram%0d", t, i), dut.dmem.RAM[i], m_dm[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, instruction ROM depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 64, data RAM depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have no other ports; all state SHALL be observable hierarchically.
REQ-006 SHALL expose instruction ROM as array imem.INSTRROM[0:IMEM_WORDS-1], 32-bit words, loadable by the bench, word-indexed by PC[31:2].
REQ-007 SHALL expose general registers as array mips.dp.gpr.registers[0:31], 32-bit, writable by the bench.

Function
REQ-008 SHALL implement a single-cycle MIPS32 subset: one instruction fetched, executed and retired per rising clk edge.
REQ-009 SHALL hold PC at 0 while reset is low; first instruction executes on the first rising edge after reset deasserts.
REQ-010 SHALL default PC update to PC+4.
REQ-011 SHALL support R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr; writes go to rd.
REQ-012 SHALL support I-type addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne; writes go to rt.
REQ-013 SHALL support J-type j and jal; target = {PC+4[31:28], imm26, 2'b00}.
REQ-014 SHALL write PC+4 to register 31 on jal; jr SHALL set PC to rs.
REQ-015 SHALL set branch target = PC+4 + (sign-extended imm16 << 2); beq taken if rs==rt, bne if rs!=rt.
REQ-016 SHALL sign-extend imm for addi/addiu/slti/sltiu/lw/sw and zero-extend for andi/ori/xori; lui writes {imm16,16'h0}.
REQ-017 SHALL wrap all add/sub results mod 2^32; no overflow exceptions, no traps.
REQ-018 SHALL support multu rs,rt writing 64-bit unsigned product to HI/LO, plus mfhi and mflo to rd; HI/LO SHALL reset to 0.
REQ-019 SHALL keep register 0 reading as 0; writes to register 0 discarded.
REQ-020 SHALL read registers combinationally; write on rising edge; a same-cycle read of the written register SHALL return the old value.
REQ-021 SHALL implement data RAM of DMEM_WORDS words, word-addressed by ALU result [31:2]; lw combinational read, sw write on rising edge; addresses wrap modulo depth.
REQ-022 SHALL treat unsupported opcodes/functs as no-ops (no register/memory write, PC+4).
REQ-023 SHALL wrap PC fetch index modulo IMEM_WORDS.

Reset
REQ-024 SHALL asynchronously force PC=0, HI=LO=0 on reset low, with no register or memory write while low.
REQ-025 SHALL NOT clear registers 1..31 or data RAM on reset; bench-preloaded values SHALL survive reset.
REQ-026 SHALL on reset asserted mid-program abort the in-flight instruction (no writeback) and restart at PC 0 after deassertion.

Verification
REQ-027 SHALL pass: registers 1..31 preloaded 0xcafebabe, ROM = lui $1,0x1234; ori $1,$1,0x5678; addiu $2,$0,-1 -> after 3 cycles $1=0x12345678, $2=0xffffffff, others 0xcafebabe.
REQ-028 SHALL pass: Fibonacci loop (addi $1,$0,0; addi $2,$0,1; loop: add $3,$1,$2; add $1,$2,$0; add $2,$3,$0; j loop) run 29 cycles -> $1,$2,$3 hold consecutive Fibonacci values matching a software model, no X.
REQ-029 SHALL pass: jal to subroutine doing addi $4,$0,7; jr $31 -> $31 = caller PC+4, $4=7, execution resumes after jal.
REQ-030 SHALL pass: addi $5,$0,6; addi $6,$0,7; multu $5,$6; mflo $7; mfhi $8 -> $7=42, $8=0.
REQ-031 SHALL pass: sw $1,4($0) then lw $9,4($0) -> $9 equals $1; beq $0,$0,+1 skips next instruction; write to $0 leaves $0=0.
REQ-032 SHALL pass: reset low for 2 cycles mid-program -> PC returns to 0, no writes during reset, program reruns correctly.
